// File: rtl/soclabs_adc_sar_ctrl.sv
// Successive-approximation controller for the 8-bit SoCLabs ADC: paces the track/hold switch
// and capacitive-DAC trial codes from ADC_TICK, and resolves the comparator into DATA/READY.
module soclabs_adc_sar_ctrl #(
  parameter int unsigned SAMPLE_TICKS = 4,
  parameter int unsigned SETTLE_TICKS = 2
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       ADC_TICK,
  input  logic       ENABLE,
  input  logic       CLR_READY,
  input  logic       COMP,
  output logic       SAMPLE_HOLD,
  output logic [7:0] DAC_CODE,
  output logic [7:0] DATA,
  output logic       READY,
  output logic       OVERRUN,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONVERT,
    DONE
  } state_e;

  localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_TICKS - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_TICKS - 1);

  state_e     state_q;
  logic [7:0] cnt_q;
  logic [2:0] bit_q;
  logic [7:0] result_q;
  logic [7:0] dac_q;
  logic [7:0] data_q;
  logic       ready_q;
  logic       overrun_q;
  logic       sh_q;
  logic       sync1_q;
  logic       sync2_q;

  logic [7:0] result_d;
  logic [7:0] trial_bit_d;

  // First stage on the falling edge so the full two-flop chain resolves a new DAC code
  // within two settle ticks even when ADC_TICK is high every cycle.
  always_ff @(negedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sync1_q <= 1'b0;
    end else begin
      sync1_q <= COMP;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sync2_q <= 1'b0;
    end else begin
      sync2_q <= sync1_q;
    end
  end

  // Result with the bit under trial decided, and the next bit to try.
  always_comb begin
    result_d        = result_q;
    result_d[bit_q] = sync2_q;
    trial_bit_d     = 8'h00;
    if (bit_q != 3'd0) begin
      trial_bit_d = 8'd1 << (bit_q - 3'd1);
    end
  end

  // NOTE: every register here resets asynchronously; when two non-blocking assignments hit
  // the same register in one cycle the later one wins, which gives DONE priority over CLR_READY.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cnt_q     <= 8'h00;
      bit_q     <= 3'd7;
      result_q  <= 8'h00;
      dac_q     <= 8'h00;
      data_q    <= 8'h00;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
      sh_q      <= 1'b0;
    end else begin
      if (CLR_READY) begin
        ready_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (ADC_TICK && ENABLE) begin
            state_q <= SAMPLE;
            sh_q    <= 1'b1;
            cnt_q   <= 8'h00;
          end
        end
        SAMPLE: begin
          if (ADC_TICK) begin
            if (cnt_q == SAMPLE_LAST) begin
              state_q  <= CONVERT;
              sh_q     <= 1'b0;
              bit_q    <= 3'd7;
              result_q <= 8'h00;
              dac_q    <= 8'h80;
              cnt_q    <= 8'h00;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        CONVERT: begin
          if (ADC_TICK) begin
            if (cnt_q == SETTLE_LAST) begin
              result_q <= result_d;
              cnt_q    <= 8'h00;
              if (bit_q != 3'd0) begin
                bit_q <= bit_q - 3'd1;
                dac_q <= result_d | trial_bit_d;
              end else begin
                state_q <= DONE;
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        DONE: begin
          data_q  <= result_q;
          ready_q <= 1'b1;
          dac_q   <= 8'h00;
          if (ready_q && !CLR_READY) begin
            overrun_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign SAMPLE_HOLD = sh_q;
  assign DAC_CODE    = dac_q;
  assign DATA        = data_q;
  assign READY       = ready_q;
  assign OVERRUN     = overrun_q;
  assign BUSY        = (state_q != IDLE);

endmodule
